// File: rtl/cc_dir_ctrl.sv
// Sequencing front-end for the 1024x136 coherence-directory SRAM: clears the directory by sweep,
// then issues masked writes and reads one per cycle and returns read data through a 2-entry buffer.
module cc_dir_ctrl #(
  parameter int ENTRIES    = 1024,
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 136,
  parameter int MASK_W     = 8,
  parameter int RESP_DEPTH = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [MASK_W-1:0] req_wmask,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  input  logic              clear_req,
  output logic              init_busy,
  output logic [ADDR_W-1:0] RW0_addr,
  output logic              RW0_en,
  output logic              RW0_wmode,
  output logic [DATA_W-1:0] RW0_wdata,
  output logic [MASK_W-1:0] RW0_wmask,
  input  logic [DATA_W-1:0] RW0_rdata
);
  typedef enum logic [1:0] {INIT, RUN, DRAIN} state_t;

  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(ENTRIES - 1);
  localparam logic [1:0]        DEPTH = 2'(RESP_DEPTH);

  state_t            state, next_state;
  logic [ADDR_W-1:0] sweep_cnt;
  logic              rd_inflight;
  logic [1:0]        buf_cnt;
  logic [DATA_W-1:0] head_q, tail_q;
  logic [1:0]        occ;
  logic              rd_issue, wr_issue, pop;

  // Occupancy counts the inflight read so a granted read always has a buffer slot.
  assign occ      = buf_cnt + {1'b0, rd_inflight};
  assign rd_issue = (state == RUN) && req_valid && !req_write && (occ < DEPTH);
  assign wr_issue = (state == RUN) && req_valid && req_write;

  // The landing read is presented straight from the SRAM when the buffer is empty.
  assign resp_valid = (buf_cnt != 2'd0) || rd_inflight;
  assign resp_rdata = (buf_cnt == 2'd0 && rd_inflight) ? RW0_rdata : head_q;
  assign pop        = resp_valid && resp_ready;
  assign init_busy  = (state == INIT);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= INIT;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      INIT:    if (sweep_cnt == LAST) next_state = RUN;
      RUN:     if (clear_req) next_state = DRAIN;
      // Nothing issues here, so the only outstanding read lands at this edge.
      DRAIN:   next_state = INIT;
      default: next_state = INIT;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    RW0_en    = 1'b0;
    RW0_wmode = 1'b0;
    RW0_addr  = '0;
    RW0_wdata = '0;
    RW0_wmask = '0;
    case (state)
      INIT: if (reset_n) begin
        RW0_en    = 1'b1;
        RW0_wmode = 1'b1;
        RW0_addr  = sweep_cnt;
        RW0_wmask = '1;
      end
      RUN: begin
        req_ready = req_write || (occ < DEPTH);
        if (rd_issue || wr_issue) begin
          RW0_en   = 1'b1;
          RW0_addr = req_addr;
        end
        if (wr_issue) begin
          RW0_wmode = 1'b1;
          RW0_wdata = req_wdata;
          RW0_wmask = req_wmask;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sweep_cnt   <= '0;
      rd_inflight <= 1'b0;
      buf_cnt     <= 2'd0;
      head_q      <= '0;
      tail_q      <= '0;
    end else begin
      if (state == INIT) sweep_cnt <= sweep_cnt + 1'b1;
      rd_inflight <= rd_issue;
      case (buf_cnt)
        2'd0: if (rd_inflight && !pop) begin
          head_q  <= RW0_rdata;
          buf_cnt <= 2'd1;
        end
        2'd1: begin
          if (rd_inflight && pop) head_q <= RW0_rdata;
          else if (rd_inflight) begin
            tail_q  <= RW0_rdata;
            buf_cnt <= 2'd2;
          end else if (pop) buf_cnt <= 2'd0;
        end
        default: if (pop) begin
          head_q <= tail_q;
          if (rd_inflight) tail_q <= RW0_rdata;
          else             buf_cnt <= 2'd1;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset_n) assert (!(rd_inflight && !pop && buf_cnt == 2'd2));
  end

endmodule

// File: tb/tb_cc_dir_ctrl.sv
// Bench for cc_dir_ctrl: SRAM model on RW0, a directory/response-queue reference model, and
// scenario tasks covering sweep, issue, backpressure, clear and mid-sweep reset.
module tb_cc_dir_ctrl;
  localparam int AW = 10;
  localparam int DW = 136;
  localparam int MW = 8;
  localparam int N  = 1024;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          req_valid, req_ready, req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [MW-1:0] req_wmask;
  logic          resp_valid, resp_ready;
  logic [DW-1:0] resp_rdata;
  logic          clear_req, init_busy;
  logic [AW-1:0] RW0_addr;
  logic          RW0_en, RW0_wmode;
  logic [DW-1:0] RW0_wdata;
  logic [MW-1:0] RW0_wmask;
  logic [DW-1:0] RW0_rdata;

  int checks = 0;
  int errors = 0;

  cc_dir_ctrl dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .clear_req(clear_req), .init_busy(init_busy),
    .RW0_addr(RW0_addr), .RW0_en(RW0_en), .RW0_wmode(RW0_wmode),
    .RW0_wdata(RW0_wdata), .RW0_wmask(RW0_wmask), .RW0_rdata(RW0_rdata)
  );

  always #5 clock = ~clock;

  // Directory SRAM: single RW port, per-way write mask, read data one cycle after issue.
  logic [DW-1:0] mem [N];
  always @(posedge clock) begin
    if (RW0_en) begin
      if (RW0_wmode) begin
        for (int k = 0; k < MW; k++)
          if (RW0_wmask[k]) mem[RW0_addr][k*17 +: 17] <= RW0_wdata[k*17 +: 17];
      end else begin
        RW0_rdata <= mem[RW0_addr];
      end
    end
  end

  // Reference: directory contents as seen by requests, plus reads owed to the consumer in order.
  logic [DW-1:0] ref_dir [N];
  logic [DW-1:0] exp_q [$];

  logic          s_ready, s_acc, s_pop, s_unexp, s_en, s_wmode, s_busy, s_rvalid;
  logic [DW-1:0] s_rdata, s_exp, s_wdata;
  logic [AW-1:0] s_addr;
  logic [MW-1:0] s_wmask;

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] d,
                                          input logic [MW-1:0] m);
    logic [DW-1:0] r;
    r = old;
    for (int k = 0; k < MW; k++) if (m[k]) r[k*17 +: 17] = d[k*17 +: 17];
    return r;
  endfunction

  function automatic logic [DW-1:0] rand_data();
    return DW'({$urandom, $urandom, $urandom, $urandom, $urandom});
  endfunction

  task automatic model_clear();
    for (int i = 0; i < N; i++) ref_dir[i] = '0;
  endtask

  // Drive one cycle, sample everything mid-cycle, advance the reference model.
  task automatic step(input logic v, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [MW-1:0] m, input logic rr, input logic clr);
    @(negedge clock);
    req_valid = v; req_write = w; req_addr = a; req_wdata = d; req_wmask = m;
    resp_ready = rr; clear_req = clr;
    #1;
    s_ready = req_ready; s_acc = v && req_ready;
    s_rvalid = resp_valid; s_pop = resp_valid && rr; s_rdata = resp_rdata;
    s_en = RW0_en; s_wmode = RW0_wmode; s_addr = RW0_addr; s_wdata = RW0_wdata; s_wmask = RW0_wmask;
    s_busy = init_busy;
    s_unexp = 1'b0; s_exp = '0;
    if (s_pop) begin
      if (exp_q.size() == 0) s_unexp = 1'b1;
      else s_exp = exp_q.pop_front();
    end
    if (s_acc) begin
      if (w) ref_dir[a] = merge(ref_dir[a], d, m);
      else   exp_q.push_back(ref_dir[a]);
    end
    @(posedge clock);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 10'h3FF; req_wdata = '1; req_wmask = '1;
    resp_ready = 1'b1; clear_req = 1'b0;
    model_clear();
    repeat (3) @(posedge clock);
    #1;
    checks++; if (init_busy !== 1'b1) begin errors++; $display("FAIL reset_init_busy: got %b want 1", init_busy); end
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready: got %b want 0", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
    checks++; if (resp_rdata !== '0) begin errors++; $display("FAIL reset_resp_rdata: got %h want 0", resp_rdata); end
    checks++;
    if (RW0_en !== 1'b0 || RW0_wmode !== 1'b0 || RW0_addr !== '0 || RW0_wdata !== '0 || RW0_wmask !== '0) begin
      errors++;
      $display("FAIL reset_rw0: got en=%b wmode=%b addr=%h wmask=%h want all 0", RW0_en, RW0_wmode, RW0_addr, RW0_wmask);
    end
    @(posedge clock); #2;
    req_valid = 1'b0;
    reset_n = 1'b1;
  endtask

  // Caller arranges for the next cycle to be the first sweep cycle.
  task automatic test_sweep(input string tag);
    for (int i = 0; i < N; i++) begin
      step(1'b1, i[0], 10'($urandom), rand_data(), 8'hFF, 1'b1, i == 7);
      checks++;
      if (s_busy !== 1'b1 || s_en !== 1'b1 || s_wmode !== 1'b1 || s_wmask !== 8'hFF ||
          s_wdata !== '0 || s_addr !== AW'(i) || s_ready !== 1'b0) begin
        errors++;
        $display("FAIL %s_sweep_cycle%0d: got busy=%b en=%b wmode=%b wmask=%h addr=%0d ready=%b want 1 1 1 ff %0d 0",
                 tag, i, s_busy, s_en, s_wmode, s_wmask, s_addr, s_ready, i);
      end
      if (s_pop) begin
        checks++;
        if (s_unexp || s_rdata !== s_exp) begin
          errors++; $display("FAIL %s_sweep_resp: got %h want %h", tag, s_rdata, s_exp);
        end
      end
    end
    step(1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0);
    checks++;
    if (s_busy !== 1'b0 || s_ready !== 1'b1 || s_en !== 1'b0) begin
      errors++; $display("FAIL %s_sweep_end: got busy=%b ready=%b en=%b want 0 1 0", tag, s_busy, s_ready, s_en);
    end
  endtask

  task automatic test_write_read();
    logic [DW-1:0] d;
    d = 136'h12_3456_789A_BCDE_F012_3456_789A_BCDE_ABCD;
    step(1'b1, 1'b1, 10'h155, d, 8'hFF, 1'b1, 1'b0);
    checks++;
    if (!s_acc || s_en !== 1'b1 || s_wmode !== 1'b1 || s_addr !== 10'h155 || s_wdata !== d || s_wmask !== 8'hFF) begin
      errors++; $display("FAIL wr_issue: got acc=%b en=%b wmode=%b addr=%h wmask=%h", s_acc, s_en, s_wmode, s_addr, s_wmask);
    end
    step(1'b1, 1'b0, 10'h155, rand_data(), 8'hFF, 1'b1, 1'b0);
    checks++;
    if (!s_acc || s_en !== 1'b1 || s_wmode !== 1'b0 || s_addr !== 10'h155 || s_wdata !== '0 || s_wmask !== '0) begin
      errors++; $display("FAIL rd_issue: got acc=%b en=%b wmode=%b addr=%h wmask=%h", s_acc, s_en, s_wmode, s_addr, s_wmask);
    end
    checks++; if (s_rvalid !== 1'b0) begin errors++; $display("FAIL rd_early_valid: got %b want 0", s_rvalid); end
    step(1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0);
    checks++; if (s_rvalid !== 1'b1) begin errors++; $display("FAIL rd_latency: got valid=%b want 1", s_rvalid); end
    checks++; if (s_rdata !== d) begin errors++; $display("FAIL rd_data: got %h want %h", s_rdata, d); end
  endtask

  task automatic test_partial_write();
    step(1'b1, 1'b1, 10'h2A0, '1, 8'h01, 1'b1, 1'b0);
    step(1'b1, 1'b0, 10'h2A0, '0, '0, 1'b1, 1'b0);
    step(1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0);
    checks++;
    if (s_rvalid !== 1'b1 || s_rdata !== 136'h1FFFF) begin
      errors++; $display("FAIL partial_write: got valid=%b data=%h want 1 1ffff", s_rvalid, s_rdata);
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] da, db, dc, dx, dn;
    da = rand_data(); db = rand_data(); dc = rand_data(); dx = rand_data(); dn = rand_data();
    step(1'b1, 1'b1, 10'h010, da, 8'hFF, 1'b1, 1'b0);
    step(1'b1, 1'b1, 10'h020, db, 8'hFF, 1'b1, 1'b0);
    step(1'b1, 1'b1, 10'h030, dc, 8'hFF, 1'b1, 1'b0);
    step(1'b1, 1'b1, 10'h050, dx, 8'hFF, 1'b1, 1'b0);
    step(1'b1, 1'b0, 10'h010, '0, '0, 1'b0, 1'b0);
    checks++; if (!s_acc) begin errors++; $display("FAIL bp_rd0_acc: got 0 want 1"); end
    step(1'b1, 1'b0, 10'h020, '0, '0, 1'b0, 1'b0);
    checks++; if (!s_acc) begin errors++; $display("FAIL bp_rd1_acc: got 0 want 1"); end
    step(1'b1, 1'b0, 10'h030, '0, '0, 1'b0, 1'b0);
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL bp_rd2_ready: got %b want 0", s_ready); end
    step(1'b1, 1'b1, 10'h040, rand_data(), 8'h0F, 1'b0, 1'b0);
    checks++; if (!s_acc || s_en !== 1'b1) begin errors++; $display("FAIL bp_write_acc: got acc=%b en=%b want 1 1", s_acc, s_en); end
    step(1'b1, 1'b0, 10'h030, '0, '0, 1'b1, 1'b0);
    checks++; if (s_acc) begin errors++; $display("FAIL bp_full_ready: got acc=1 want 0"); end
    checks++; if (!s_pop || s_rdata !== da) begin errors++; $display("FAIL bp_pop0: got %h want %h", s_rdata, da); end
    step(1'b1, 1'b0, 10'h030, '0, '0, 1'b1, 1'b0);
    checks++; if (!s_acc) begin errors++; $display("FAIL bp_rd2_acc: got 0 want 1"); end
    checks++; if (!s_pop || s_rdata !== db) begin errors++; $display("FAIL bp_pop1: got %h want %h", s_rdata, db); end
    step(1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0);
    checks++; if (!s_pop || s_rdata !== dc) begin errors++; $display("FAIL bp_pop2: got %h want %h", s_rdata, dc); end
    // Read then write of the same entry on consecutive cycles.
    step(1'b1, 1'b0, 10'h050, '0, '0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 10'h050, dn, 8'hFF, 1'b1, 1'b0);
    checks++; if (!s_pop || s_rdata !== dx) begin errors++; $display("FAIL order_old: got %h want %h", s_rdata, dx); end
    step(1'b1, 1'b0, 10'h050, '0, '0, 1'b1, 1'b0);
    step(1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0);
    checks++; if (!s_pop || s_rdata !== dn) begin errors++; $display("FAIL order_new: got %h want %h", s_rdata, dn); end
  endtask

  task automatic test_random();
    logic          v, w, rr, pred_ready, pred_valid;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [MW-1:0] m;
    for (int i = 0; i < 400; i++) begin
      v = ($urandom_range(0, 3) != 0);
      w = $urandom_range(0, 1) == 1;
      a = 10'h300 + 10'($urandom_range(0, 7));
      d = rand_data();
      m = 8'($urandom);
      rr = ($urandom_range(0, 9) < 6);
      pred_ready = w || (exp_q.size() < 2);
      pred_valid = (exp_q.size() > 0);
      step(v, w, a, d, m, rr, 1'b0);
      checks++; if (s_ready !== pred_ready) begin errors++; $display("FAIL rnd_ready@%0d: got %b want %b", i, s_ready, pred_ready); end
      checks++; if (s_rvalid !== pred_valid) begin errors++; $display("FAIL rnd_valid@%0d: got %b want %b", i, s_rvalid, pred_valid); end
      checks++;
      if (s_en !== (v && pred_ready) || (v && pred_ready && (s_addr !== a || s_wmode !== w))) begin
        errors++; $display("FAIL rnd_issue@%0d: got en=%b addr=%h wmode=%b want en=%b addr=%h wmode=%b",
                           i, s_en, s_addr, s_wmode, v && pred_ready, a, w);
      end
      if (s_pop) begin
        checks++;
        if (s_unexp || s_rdata !== s_exp) begin errors++; $display("FAIL rnd_data@%0d: got %h want %h", i, s_rdata, s_exp); end
      end
    end
    for (int i = 0; i < 8 && exp_q.size() > 0; i++) begin
      step(1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0);
      if (s_pop) begin
        checks++;
        if (s_unexp || s_rdata !== s_exp) begin errors++; $display("FAIL rnd_drain_data: got %h want %h", s_rdata, s_exp); end
      end
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rnd_drain_timeout: got %0d pending want 0", exp_q.size()); end
  endtask

  task automatic test_clear();
    logic [DW-1:0] da, db;
    da = rand_data(); db = rand_data();
    step(1'b1, 1'b1, 10'h0A0, da, 8'hFF, 1'b1, 1'b0);
    step(1'b1, 1'b1, 10'h0B0, db, 8'hFF, 1'b1, 1'b0);
    step(1'b1, 1'b0, 10'h0A0, '0, '0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 10'h0B0, '0, '0, 1'b0, 1'b0);
    // clear with a same-cycle write: the write still issues
    step(1'b1, 1'b1, 10'h0C0, rand_data(), 8'hFF, 1'b0, 1'b1);
    checks++;
    if (!s_acc || s_en !== 1'b1 || s_addr !== 10'h0C0) begin
      errors++; $display("FAIL clr_same_cycle_wr: got acc=%b en=%b addr=%h want 1 1 0c0", s_acc, s_en, s_addr);
    end
    model_clear();
    step(1'b1, 1'b1, 10'h0D0, rand_data(), 8'hFF, 1'b0, 1'b0);
    checks++;
    if (s_busy !== 1'b0 || s_ready !== 1'b0 || s_en !== 1'b0 || s_rvalid !== 1'b1) begin
      errors++; $display("FAIL clr_drain: got busy=%b ready=%b en=%b valid=%b want 0 0 0 1", s_busy, s_ready, s_en, s_rvalid);
    end
    test_sweep("clear");
    step(1'b1, 1'b0, 10'h0A0, '0, '0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 10'h0C0, '0, '0, 1'b1, 1'b0);
    checks++; if (!s_pop || s_rdata !== '0) begin errors++; $display("FAIL clr_post_a: got %h want 0", s_rdata); end
    step(1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0);
    checks++; if (!s_pop || s_rdata !== '0) begin errors++; $display("FAIL clr_post_c: got %h want 0", s_rdata); end
  endtask

  task automatic test_reset_mid_sweep();
    step(1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b1);
    model_clear();
    step(1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 500; i++) step(1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0);
    @(negedge clock); #1;
    checks++;
    if (RW0_en !== 1'b1 || RW0_addr !== 10'd500) begin
      errors++; $display("FAIL mid_sweep_addr: got en=%b addr=%0d want 1 500", RW0_en, RW0_addr);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (RW0_en !== 1'b0 || RW0_addr !== '0 || RW0_wmask !== '0 || RW0_wmode !== 1'b0 || init_busy !== 1'b1 ||
        req_ready !== 1'b0 || resp_valid !== 1'b0 || resp_rdata !== '0) begin
      errors++; $display("FAIL mid_sweep_reset: got en=%b addr=%0d wmask=%h busy=%b ready=%b valid=%b",
                         RW0_en, RW0_addr, RW0_wmask, init_busy, req_ready, resp_valid);
    end
    exp_q.delete();
    @(posedge clock); @(posedge clock); #2;
    reset_n = 1'b1;
    test_sweep("restart");
    step(1'b1, 1'b0, 10'h155, '0, '0, 1'b1, 1'b0);
    step(1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0);
    checks++; if (!s_pop || s_rdata !== '0) begin errors++; $display("FAIL restart_read: got %h want 0", s_rdata); end
  endtask

  initial begin
    test_reset();
    test_sweep("init");
    test_write_read();
    test_partial_write();
    test_back_to_back();
    test_random();
    test_clear();
    test_reset_mid_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule
